wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 register file's single write port. Each cycle it produces one write: rf_we, rf_rd, rf_wd.
- Merges two writeback sources:
  - ALU results, buffered in a small FIFO with a valid/ready handshake.
  - Load returns from data memory. These have no backpressure and always take priority.
- Suppresses writes to x0.
- Squashes stale buffered ALU results that a load to the same register supersedes.

Parameters:
- DEPTH, 4, ALU result FIFO depth. Must be a power of 2, at least 2.
- AW, 2, FIFO pointer width. Must equal log2(DEPTH).

Ports:
- clk  in  1  system clock. All state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  an ALU result is offered this cycle.
- alu_ready  out  1  FIFO can accept an ALU result.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  32  ALU result data.
- ld_valid  in  1  load data returns this cycle. Must be consumed this cycle.
- ld_rd  in  5  load destination register.
- ld_wd  in  32  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write address (registered).
- rf_wd  out  32  register-file write data (registered).
- pend_cnt  out  AW+1  number of FIFO entries currently occupied.

Behaviour:
- Reset (async assert, sync release):
  - rf_we=0, rf_rd=0, rf_wd=0, pend_cnt=0, alu_ready=0 while rst is high.
  - FIFO pointers and all entry valid bits cleared.
  - Reset mid-operation discards all pending entries. No write is issued after reset.
- alu_ready = !rst && (pend_cnt != DEPTH). It is combinational from registered state only.
- ALU accept = alu_valid && alu_ready.
  - On accept with alu_rd != 0: push {v=1, rd, wd} at the write pointer.
  - On accept with alu_rd == 0: the handshake completes but nothing is enqueued.
- Issue selection, evaluated each cycle on current state:
  - If ld_valid: issue the load. Next cycle rf_we = (ld_rd != 0), rf_rd = ld_rd, rf_wd = ld_wd.
  - Else if FIFO non-empty and head.v=1: pop the head. Next cycle rf_we=1 with the head's rd and wd.
  - Else if FIFO non-empty and head.v=0 (squashed): pop the head silently. Next cycle rf_we=0.
  - Else: rf_we=0 next cycle. rf_rd and rf_wd hold their previous values.
- Latency:
  - Load returned in cycle N gives rf_we=1 in cycle N+1.
  - ALU result accepted in cycle N enters the FIFO at N+1. It reaches rf_we at N+2 at the earliest; there is no bypass around the FIFO.
- Squash rule: when ld_valid and ld_rd != 0, every FIFO entry with v=1 and rd == ld_rd gets v cleared at the next edge. Those entries are older and must not overwrite the load value.
  - An ALU result with alu_rd == ld_rd accepted in the same cycle is younger. It is enqueued with v=1 and is not squashed.
- Simultaneous push and pop: pend_cnt is unchanged. A pop frees a slot only from the next cycle, because alu_ready does not look ahead.
- Pointers wrap modulo DEPTH. pend_cnt ranges 0..DEPTH.
- Sustained ld_valid starves the FIFO. This is permitted; alu_ready drops once the FIFO is full.
- Ordering: ALU results are written in acceptance order. A squashed entry never asserts rf_we.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds these ports:
  - byp_rs1 in 5, byp_rs2 in 5.
  - byp_hit1 out 1, byp_d1 out 32.
  - byp_hit2 out 1, byp_d2 out 32.
- Combinational lookup for each rs:
  - Search the valid FIFO entries (youngest first), then the registered write (rf_we && rf_rd).
  - hit=1 with the data of the first match.
  - rs == 0 never hits.
- When not defined, these ports do not exist and no lookup logic is built.

Test Plan:
- Reset: hold rst 3 cycles with alu_valid=1 -> alu_ready=0, rf_we=0, pend_cnt=0. After release, alu_ready=1 within 1 cycle.
- ALU path: alu_rd=5, alu_wd=0x11 accepted at cycle N, no loads -> pend_cnt=1 at N+1; rf_we=1, rf_rd=5, rf_wd=0x11 at N+2; pend_cnt=0 at N+2.
- Load priority and full: FIFO holds 4 entries, ld_valid held 3 cycles with ld_rd=7 -> rf_rd=7 for 3 writes, alu_ready=0 throughout, then the 4 ALU entries are written in order.
- Squash: FIFO holds rd=3 (0xAA) and rd=4 (0xBB), then ld_valid with ld_rd=3, ld_wd=0x55 -> writes in order are x3=0x55, then a silent pop (rf_we=0), then x4=0xBB. x3 never becomes 0xAA.
- x0 suppression: alu_rd=0 accepted -> pend_cnt unchanged. ld_rd=0 with ld_valid -> rf_we=0 the next cycle.
- Bypass (WB_BYPASS_EN): FIFO holds rd=6 with 0x1 then rd=6 with 0x2, byp_rs1=6 -> byp_hit1=1, byp_d1=0x2. byp_rs2=0 -> byp_hit2=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: the writer for the register file's single write port.
// It merges buffered ALU results with load returns. Loads have no
// backpressure and always win the port. Writes to x0 are suppressed.
// A load squashes older buffered ALU results aimed at the same register.
// Optional feature macro: WB_BYPASS_EN adds a combinational lookup. The
// lookup searches pending FIFO entries and then the registered write.
//
// Handshake: an ALU result transfers on a rising edge where alu_valid and
// alu_ready are both high. alu_ready is derived only from registered
// occupancy, so a pop does not free a slot until the following cycle.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_wd,
  input  logic          ld_valid,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_wd,
`ifdef WB_BYPASS_EN
  input  logic [4:0]    byp_rs1,
  input  logic [4:0]    byp_rs2,
  output logic          byp_hit1,
  output logic [31:0]   byp_d1,
  output logic          byp_hit2,
  output logic [31:0]   byp_d2,
`endif
  output logic          rf_we,
  output logic [4:0]    rf_rd,
  output logic [31:0]   rf_wd,
  output logic [AW:0]   pend_cnt
);

  // FIFO storage: valid bit, destination, data per slot
  logic          r_v    [DEPTH];
  logic [4:0]    r_rd_q [DEPTH];
  logic [31:0]   r_wd_q [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  // Registered write port
  logic          r_we;
  logic [4:0]    r_rd;
  logic [31:0]   r_wd;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_squash;

  assign alu_ready = !rst && (r_cnt != (AW+1)'(DEPTH));
  assign w_accept  = alu_valid && alu_ready;
  // An accepted result for x0 completes the handshake but is dropped
  assign w_push    = w_accept && (alu_rd != 5'd0);
  // The FIFO head only drains on cycles without a load return
  assign w_pop     = !ld_valid && (r_cnt != '0);
  assign w_squash  = ld_valid && (ld_rd != 5'd0);

  assign rf_we    = r_we;
  assign rf_rd    = r_rd;
  assign rf_wd    = r_wd;
  assign pend_cnt = r_cnt;

  // FIFO state: squash older matches, pop the head, push the new result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_v[i]    <= 1'b0;
        r_rd_q[i] <= '0;
        r_wd_q[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      // Squash comes first so a same-cycle push to the same rd survives
      if (w_squash) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd_q[i] == ld_rd) r_v[i] <= 1'b0;
        end
      end
      // Freed slots are invalidated so the bypass never sees stale data
      if (w_pop) begin
        r_v[r_rptr] <= 1'b0;
        r_rptr      <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_v[r_wptr]    <= 1'b1;
        r_rd_q[r_wptr] <= alu_rd;
        r_wd_q[r_wptr] <= alu_wd;
        r_wptr         <= r_wptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Write port: a load wins, else the head drains, and squashed heads write nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else if (ld_valid) begin
      r_we <= (ld_rd != 5'd0);
      r_rd <= ld_rd;
      r_wd <= ld_wd;
    end else if (w_pop) begin
      r_we <= r_v[r_rptr];
      if (r_v[r_rptr]) begin
        r_rd <= r_rd_q[r_rptr];
        r_wd <= r_wd_q[r_rptr];
      end
    end else begin
      r_we <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Youngest match wins: scan oldest to youngest and let later hits override
  function automatic logic [32:0] byp_lookup(input logic [4:0] rs);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    idx = '0;
    if (rs != 5'd0) begin
      if (r_we && (r_rd == rs)) res = {1'b1, r_wd};
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rptr + AW'(k);
        if (((AW+1)'(k) < r_cnt) && r_v[idx] && (r_rd_q[idx] == rs))
          res = {1'b1, r_wd_q[idx]};
      end
    end
    return res;
  endfunction

  // Combinational bypass lookup for both source operands
  always_comb begin
    {byp_hit1, byp_d1} = byp_lookup(byp_rs1);
    {byp_hit2, byp_d2} = byp_lookup(byp_rs2);
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios with literal expectations,
// then random traffic checked against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_wd;
  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_wd;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wd;
  logic [AW:0]   pend_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]    byp_rs1;
  logic [4:0]    byp_rs2;
  logic          byp_hit1;
  logic [31:0]   byp_d1;
  logic          byp_hit2;
  logic [31:0]   byp_d2;
`endif

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd),
`ifdef WB_BYPASS_EN
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
    .byp_hit1(byp_hit1), .byp_d1(byp_d1),
    .byp_hit2(byp_hit2), .byp_d2(byp_d2),
`endif
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pend_cnt(pend_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pending ALU results as {v, rd, wd}, oldest at the front
  logic [37:0] exp_q[$];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_we = 1'b0;
    exp_rd = '0;
    exp_wd = '0;
  endtask

  // Advance the model by one rising edge using the inputs held at that edge
  task automatic model_edge();
    logic        accept;
    logic [37:0] e;
    if (rst) begin
      model_clear();
    end else begin
      accept = alu_valid && (exp_q.size() != DEPTH);
      if (ld_valid) begin
        exp_we = (ld_rd != 0);
        exp_rd = ld_rd;
        exp_wd = ld_wd;
        if (ld_rd != 0)
          foreach (exp_q[i]) if (exp_q[i][36:32] == ld_rd) exp_q[i][37] = 1'b0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_we = e[37];
        if (e[37]) begin
          exp_rd = e[36:32];
          exp_wd = e[31:0];
        end
      end else begin
        exp_we = 1'b0;
      end
      if (accept && alu_rd != 0) exp_q.push_back({1'b1, alu_rd, alu_wd});
    end
  endtask

  // Driver: hold inputs across one rising edge, then advance the model
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    ld_valid = lv;  ld_rd = lrd;  ld_wd = lwd;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we", 32'(rf_we), 32'(exp_we));
      if (exp_we || rst) begin
        chk("rf_rd", 32'(rf_rd), 32'(exp_rd));
        chk("rf_wd", rf_wd, exp_wd);
      end
      chk("pend_cnt", 32'(pend_cnt), exp_q.size());
      chk("alu_ready", 32'(alu_ready), 32'(!rst && exp_q.size() != DEPTH));
`ifdef WB_BYPASS_EN
      byp_check(byp_rs1, byp_hit1, byp_d1, "byp1");
      byp_check(byp_rs2, byp_hit2, byp_d2, "byp2");
`endif
    end
  end

`ifdef WB_BYPASS_EN
  task automatic byp_check(input logic [4:0] rs, input logic hit, input logic [31:0] d,
                           input string name);
    logic        eh;
    logic [31:0] ed;
    eh = 1'b0;
    ed = '0;
    if (rs != 0) begin
      if (exp_we && exp_rd == rs) begin eh = 1'b1; ed = exp_wd; end
      foreach (exp_q[i])
        if (exp_q[i][37] && exp_q[i][36:32] == rs) begin eh = 1'b1; ed = exp_q[i][31:0]; end
    end
    chk({name, "_hit"}, 32'(hit), 32'(eh));
    if (eh) chk({name, "_d"}, d, ed);
  endtask
`endif

  initial begin
    rst = 1'b1;
    model_clear();
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_wd = '0;
`ifdef WB_BYPASS_EN
    byp_rs1 = '0; byp_rs2 = '0;
`endif

    // Reset held 3 cycles with an ALU result offered
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
    chk_en = 1'b1;
    chk("rst_ready", 32'(alu_ready), 32'h0);
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_cnt", 32'(pend_cnt), 32'h0);
    alu_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(alu_ready), 32'h1);

    // ALU path: two-cycle latency to the write port
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("alu_cnt_n1", 32'(pend_cnt), 32'h1);
    chk("alu_we_n1", 32'(rf_we), 32'h0);
    idle();
    chk("alu_we_n2", 32'(rf_we), 32'h1);
    chk("alu_rd_n2", 32'(rf_rd), 32'h5);
    chk("alu_wd_n2", rf_wd, 32'h11);
    chk("alu_cnt_n2", 32'(pend_cnt), 32'h0);

    // Load priority with a full FIFO
    for (int i = 0; i < 4; i++) drive(1'b1, 5'(10 + i), 32'hA0 + i, 1'b1, 5'd1, 32'h1);
    chk("full_cnt", 32'(pend_cnt), 32'h4);
    chk("full_ready", 32'(alu_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'h70 + i);
      chk("ld_pri_rd", 32'(rf_rd), 32'h7);
      chk("ld_pri_wd", rf_wd, 32'h70 + i);
      chk("ld_pri_ready", 32'(alu_ready), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("drain_we", 32'(rf_we), 32'h1);
      chk("drain_rd", 32'(rf_rd), 32'(10 + i));
      chk("drain_wd", rf_wd, 32'hA0 + i);
    end
    chk("drain_cnt", 32'(pend_cnt), 32'h0);

    // Squash: load to x3 supersedes the buffered 0xAA
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd1, 32'h0);
    drive(1'b1, 5'd4, 32'hBB, 1'b1, 5'd1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h55);
    chk("sq_ld_rd", 32'(rf_rd), 32'h3);
    chk("sq_ld_wd", rf_wd, 32'h55);
    idle();
    chk("sq_silent", 32'(rf_we), 32'h0);
    idle();
    chk("sq_x4_we", 32'(rf_we), 32'h1);
    chk("sq_x4_rd", 32'(rf_rd), 32'h4);
    chk("sq_x4_wd", rf_wd, 32'hBB);

    // Younger same-rd result accepted alongside the load survives
    drive(1'b1, 5'd8, 32'h1, 1'b1, 5'd1, 32'h0);
    drive(1'b1, 5'd8, 32'h2, 1'b1, 5'd8, 32'hC);
    idle();
    chk("young_silent", 32'(rf_we), 32'h0);
    idle();
    chk("young_rd", 32'(rf_rd), 32'h8);
    chk("young_wd", rf_wd, 32'h2);

    // x0 suppression on both sources
    drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
    chk("x0_alu_cnt", 32'(pend_cnt), 32'h0);
    idle();
    chk("x0_alu_we", 32'(rf_we), 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h33);
    chk("x0_ld_we", 32'(rf_we), 32'h0);

`ifdef WB_BYPASS_EN
    // Bypass picks the youngest FIFO match
    drive(1'b1, 5'd6, 32'h1, 1'b1, 5'd1, 32'h0);
    drive(1'b1, 5'd6, 32'h2, 1'b1, 5'd1, 32'h0);
    byp_rs1 = 5'd6;
    byp_rs2 = 5'd0;
    #1;
    chk("byp_hit1", 32'(byp_hit1), 32'h1);
    chk("byp_d1", byp_d1, 32'h2);
    chk("byp_hit2", 32'(byp_hit2), 32'h0);
    idle();
    idle();
`endif

    // Reset mid-operation discards pending entries
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd2, 32'h2);
    drive(1'b1, 5'd13, 32'hC1, 1'b1, 5'd2, 32'h2);
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_cnt", 32'(pend_cnt), 32'h0);
    chk("mid_rst_we", 32'(rf_we), 32'h0);
    drive(1'b1, 5'd14, 32'hC2, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    idle();
    idle();
    chk("post_rst_we", 32'(rf_we), 32'h0);

    // Random traffic with frequent rd collisions
    for (int i = 0; i < 3000; i++) begin
`ifdef WB_BYPASS_EN
      byp_rs1 = 5'($urandom_range(0, 7));
      byp_rs2 = 5'($urandom_range(0, 7));
`endif
      drive(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 8; i++) idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
